// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx
//
// Pulls 15-bit words from an upstream FIFO that has a registered read port.
// Each word is sent as two back-to-back 8N1 UART characters: word[7:0]
// first, then {1'b0, word[14:8]}. A word occupies exactly 20 bit times on
// the line, from the first start bit to the end of the second stop bit.
// Every output comes straight from a flop.
//
// Parameters:
//   CLKS_PER_BIT  clock cycles per UART bit, 2..65535
//   READ_LATENCY  cycles from fifo_ren to valid fifo_data, at least 1
//
// Ports:
//   clk         system clock, rising edge
//   reset       synchronous, active-high reset
//   fifo_empty  upstream FIFO empty flag, looked at only while idle
//   fifo_data   upstream FIFO read data (15 bits)
//   fifo_ren    one-cycle read strobe, one per word
//   tx          UART serial line, idles high
//   busy        high whenever a word is being fetched or sent
//   done        one-cycle pulse on the last cycle of a word's second stop bit
//   words_sent  number of completed words, wraps from 255 to 0
module fifo_uart_tx #(
   parameter int CLKS_PER_BIT = 434,
   parameter int READ_LATENCY = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        fifo_empty,
   input  logic [14:0] fifo_data,
   output logic        fifo_ren,
   output logic        tx,
   output logic        busy,
   output logic        done,
   output logic [7:0]  words_sent
);

   typedef enum logic [2:0] {
      IDLE,
      REQ,
      WAIT,
      LOAD,
      START,
      DATA,
      STOP
   } state_t;

   localparam logic [15:0] BAUD_RELOAD = 16'(CLKS_PER_BIT - 1);
   localparam logic [15:0] WAIT_RELOAD = 16'(READ_LATENCY - 1);

   state_t      state, state_next;
   logic [15:0] baud_cnt, baud_next;
   logic [15:0] wait_cnt, wait_next;
   logic [2:0]  bit_idx, bit_next;
   logic        byte_sel, byte_sel_next;
   logic [14:0] word, word_next;
   logic [7:0]  words_next;
   logic [7:0]  byte_next;
   logic        tx_next;
   logic        ren_next;
   logic        busy_next;
   logic        done_next;

   // Sequencing of one word. The baud counter counts down from
   // CLKS_PER_BIT-1 and is reloaded at every bit boundary, so each bit is
   // timed on its own and no error can accumulate across the frame. The
   // word register is written only in LOAD, so fifo_data may change freely
   // at any other time without disturbing the character on the line.
   always_comb begin
      state_next    = state;
      baud_next     = baud_cnt;
      wait_next     = wait_cnt;
      bit_next      = bit_idx;
      byte_sel_next = byte_sel;
      word_next     = word;
      words_next    = words_sent;
      case (state)
         IDLE: begin
            if (!fifo_empty) begin
               state_next = REQ;
            end
         end
         REQ: begin
            state_next = WAIT;
            wait_next  = WAIT_RELOAD;
         end
         WAIT: begin
            if (wait_cnt == 16'd0) begin
               state_next = LOAD;
            end else begin
               wait_next = wait_cnt - 16'd1;
            end
         end
         LOAD: begin
            word_next     = fifo_data;
            byte_sel_next = 1'b0;
            baud_next     = BAUD_RELOAD;
            state_next    = START;
         end
         START: begin
            if (baud_cnt == 16'd0) begin
               state_next = DATA;
               bit_next   = 3'd0;
               baud_next  = BAUD_RELOAD;
            end else begin
               baud_next = baud_cnt - 16'd1;
            end
         end
         DATA: begin
            if (baud_cnt == 16'd0) begin
               baud_next = BAUD_RELOAD;
               if (bit_idx == 3'd7) begin
                  state_next = STOP;
               end else begin
                  bit_next = bit_idx + 3'd1;
               end
            end else begin
               baud_next = baud_cnt - 16'd1;
            end
         end
         STOP: begin
            if (baud_cnt == 16'd0) begin
               if (!byte_sel) begin
                  byte_sel_next = 1'b1;
                  baud_next     = BAUD_RELOAD;
                  state_next    = START;
               end else begin
                  words_next = words_sent + 8'd1;
                  state_next = IDLE;
               end
            end else begin
               baud_next = baud_cnt - 16'd1;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Outputs are computed from the upcoming state and registered alongside
   // it, so they line up with the state cycle by cycle without any
   // combinational path to the pins. done is raised for the cycle in which
   // the second stop bit's counter sits at zero, i.e. its final cycle.
   always_comb begin
      byte_next = byte_sel_next ? {1'b0, word_next[14:8]} : word_next[7:0];
      tx_next   = 1'b1;
      if (state_next == START) begin
         tx_next = 1'b0;
      end else if (state_next == DATA) begin
         tx_next = byte_next[bit_next];
      end
      ren_next  = (state_next == REQ);
      busy_next = (state_next != IDLE);
      done_next = (state_next == STOP) && byte_sel_next && (baud_next == 16'd0);
   end

   // State and output registers. Reset wins over everything else and drops
   // any frame in progress at once, including a word already read from the
   // FIFO; no done pulse is produced for it.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         baud_cnt   <= 16'd0;
         wait_cnt   <= 16'd0;
         bit_idx    <= 3'd0;
         byte_sel   <= 1'b0;
         word       <= 15'd0;
         words_sent <= 8'd0;
         tx         <= 1'b1;
         fifo_ren   <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else begin
         state      <= state_next;
         baud_cnt   <= baud_next;
         wait_cnt   <= wait_next;
         bit_idx    <= bit_next;
         byte_sel   <= byte_sel_next;
         word       <= word_next;
         words_sent <= words_next;
         tx         <= tx_next;
         fifo_ren   <= ren_next;
         busy       <= busy_next;
         done       <= done_next;
      end
   end

endmodule
